// File: rtl/polaris_bus_pkg.sv
// Shared definitions for the Polaris data/instruction bus responders:
// transfer sizes, responder states and the alignment predicate.
package polaris_bus_pkg;

  localparam logic [1:0] SIZ_BYTE  = 2'b00;
  localparam logic [1:0] SIZ_HALF  = 2'b01;
  localparam logic [1:0] SIZ_WORD  = 2'b10;
  localparam logic [1:0] SIZ_DWORD = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b01,
    StAck  = 2'b10
  } dbus_state_e;

  // An access is legal when the byte lane is a multiple of the transfer size.
  function automatic logic misaligned(input logic [2:0] lane, input logic [1:0] siz);
    logic mis;
    case (siz)
      SIZ_BYTE: mis = 1'b0;
      SIZ_HALF: mis = lane[0];
      SIZ_WORD: mis = |lane[1:0];
      default:  mis = |lane;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/polaris_dbus_lane.sv
// Byte-lane steering for a 64-bit little-endian bus: read align/extend and
// write shift with byte-enable generation.
module polaris_dbus_lane
  import polaris_bus_pkg::*;
(
  input  logic [2:0]  lane_i,
  input  logic [1:0]  siz_i,
  input  logic        sext_i,
  input  logic [63:0] rraw_i,
  output logic [63:0] rdata_o,
  input  logic [63:0] wdata_i,
  output logic [63:0] wdata_o,
  output logic [7:0]  wbe_o
);

  logic [5:0]  shamt;
  logic [63:0] rshift;
  logic [7:0]  be_base;

  assign shamt  = {lane_i, 3'b000};
  assign rshift = rraw_i >> shamt;

  always_comb begin
    rdata_o = rshift;
    case (siz_i)
      SIZ_BYTE: rdata_o = {{56{sext_i & rshift[7]}}, rshift[7:0]};
      SIZ_HALF: rdata_o = {{48{sext_i & rshift[15]}}, rshift[15:0]};
      SIZ_WORD: rdata_o = {{32{sext_i & rshift[31]}}, rshift[31:0]};
      default:  rdata_o = rshift;
    endcase
  end

  always_comb begin
    be_base = 8'hff;
    case (siz_i)
      SIZ_BYTE: be_base = 8'h01;
      SIZ_HALF: be_base = 8'h03;
      SIZ_WORD: be_base = 8'h0f;
      default:  be_base = 8'hff;
    endcase
  end

  assign wbe_o   = be_base << lane_i;
  assign wdata_o = wdata_i << shamt;

endmodule

// File: rtl/polaris_dbus_ram.sv
// Polaris D-bus responder backed by an inferred 64-bit RAM with byte enables
// and a programmable number of wait states before the acknowledge.
module polaris_dbus_ram
  import polaris_bus_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = 12,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        dcyc_i,
  input  logic        dstb_i,
  input  logic        dwe_i,
  input  logic [63:0] dadr_i,
  input  logic [63:0] ddat_i,
  input  logic [1:0]  dsiz_i,
  input  logic        dsigned_i,
  output logic        dack_o,
  output logic [63:0] ddat_o,
  output logic        derr_o
);

  localparam int unsigned Depth = 2 ** ADDR_BITS;
  localparam logic [3:0]  WaitLoad = 4'(WAIT_STATES);

  dbus_state_e          state_q;
  logic [3:0]           cnt_q;
  logic [ADDR_BITS+2:0] adr_q;
  logic [1:0]           siz_q;
  logic                 sext_q;
  logic                 we_q;
  logic [63:0]          wdat_q;
  logic [63:0]          raw_q;
  logic [63:0]          mem [Depth];

  logic                 start;
  logic                 enter_ack;
  logic                 in_idle;
  logic [ADDR_BITS+2:0] eff_adr;
  logic [1:0]           eff_siz;
  logic                 eff_sext;
  logic                 eff_we;
  logic [63:0]          eff_wdat;
  logic                 eff_mis;
  logic [ADDR_BITS-1:0] idx;
  logic                 wr_en;
  logic [63:0]          rdata;
  logic [63:0]          wdata_sh;
  logic [7:0]           wbe;
  logic                 unused_adr;

  assign unused_adr = ^dadr_i[63:ADDR_BITS+3];

  // With zero wait states the RAM is accessed on the sampling edge itself,
  // so the live bus values stand in for the not-yet-latched ones.
  assign in_idle  = (state_q == StIdle);
  assign eff_adr  = in_idle ? dadr_i[ADDR_BITS+2:0] : adr_q;
  assign eff_siz  = in_idle ? dsiz_i : siz_q;
  assign eff_sext = in_idle ? dsigned_i : sext_q;
  assign eff_we   = in_idle ? dwe_i : we_q;
  assign eff_wdat = in_idle ? ddat_i : wdat_q;
  assign eff_mis  = misaligned(eff_adr[2:0], eff_siz);
  assign idx      = eff_adr[ADDR_BITS+2:3];

  assign start     = in_idle && dcyc_i && dstb_i;
  assign enter_ack = (start && (WAIT_STATES == 0)) ||
                     ((state_q == StWait) && dcyc_i && (cnt_q == 4'd1));
  assign wr_en     = enter_ack && eff_we && !eff_mis && !reset_i;

  polaris_dbus_lane u_lane (
    .lane_i  (eff_adr[2:0]),
    .siz_i   (eff_siz),
    .sext_i  (eff_sext),
    .rraw_i  (raw_q),
    .rdata_o (rdata),
    .wdata_i (eff_wdat),
    .wdata_o (wdata_sh),
    .wbe_o   (wbe)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      adr_q   <= '0;
      siz_q   <= SIZ_BYTE;
      sext_q  <= 1'b0;
      we_q    <= 1'b0;
      wdat_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            adr_q   <= dadr_i[ADDR_BITS+2:0];
            siz_q   <= dsiz_i;
            sext_q  <= dsigned_i;
            we_q    <= dwe_i;
            wdat_q  <= ddat_i;
            cnt_q   <= WaitLoad;
            state_q <= (WAIT_STATES == 0) ? StAck : StWait;
          end
        end
        StWait: begin
          if (!dcyc_i) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_q <= StAck;
          end
        end
        StAck:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      raw_q <= '0;
    end else if (enter_ack) begin
      raw_q <= mem[idx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < 8; b++) begin
        if (wbe[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  assign dack_o = (state_q == StAck);
  assign derr_o = dack_o && misaligned(adr_q[2:0], siz_q);
  assign ddat_o = (dack_o && !we_q && !derr_o) ? rdata : 64'd0;

endmodule

// File: tb/tb_polaris_dbus_ram.sv
// Directed bench for polaris_dbus_ram with 1, 3 and 0 wait-state instances.
module tb_polaris_dbus_ram;

  logic        clk = 1'b0;
  logic [2:0]  rst, dcyc, dstb, dwe, dsigned, dack, derr;
  logic [63:0] dadr [3];
  logic [63:0] ddat [3];
  logic [63:0] rdat [3];
  logic [1:0]  dsiz [3];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  polaris_dbus_ram #(.ADDR_BITS(12), .WAIT_STATES(1)) u_ws1 (
    .clk_i(clk), .reset_i(rst[0]), .dcyc_i(dcyc[0]), .dstb_i(dstb[0]), .dwe_i(dwe[0]),
    .dadr_i(dadr[0]), .ddat_i(ddat[0]), .dsiz_i(dsiz[0]), .dsigned_i(dsigned[0]),
    .dack_o(dack[0]), .ddat_o(rdat[0]), .derr_o(derr[0])
  );

  polaris_dbus_ram #(.ADDR_BITS(12), .WAIT_STATES(3)) u_ws3 (
    .clk_i(clk), .reset_i(rst[1]), .dcyc_i(dcyc[1]), .dstb_i(dstb[1]), .dwe_i(dwe[1]),
    .dadr_i(dadr[1]), .ddat_i(ddat[1]), .dsiz_i(dsiz[1]), .dsigned_i(dsigned[1]),
    .dack_o(dack[1]), .ddat_o(rdat[1]), .derr_o(derr[1])
  );

  polaris_dbus_ram #(.ADDR_BITS(12), .WAIT_STATES(0)) u_ws0 (
    .clk_i(clk), .reset_i(rst[2]), .dcyc_i(dcyc[2]), .dstb_i(dstb[2]), .dwe_i(dwe[2]),
    .dadr_i(dadr[2]), .ddat_i(ddat[2]), .dsiz_i(dsiz[2]), .dsigned_i(dsigned[2]),
    .dack_o(dack[2]), .ddat_o(rdat[2]), .derr_o(derr[2])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One transaction; lat counts cycles from the sampling edge to dack (0 = none).
  task automatic txn(input int inst, input logic we, input logic [63:0] adr,
                     input logic [63:0] dat, input logic [1:0] siz, input logic sgn,
                     output int lat, output logic [63:0] rd, output logic er);
    @(negedge clk);
    dcyc[inst] = 1'b1; dstb[inst] = 1'b1; dwe[inst] = we; dadr[inst] = adr;
    ddat[inst] = dat; dsiz[inst] = siz; dsigned[inst] = sgn;
    @(posedge clk);
    #1 dstb[inst] = 1'b0;
    lat = 0; rd = '0; er = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (dack[inst]) begin
        lat = n; rd = rdat[inst]; er = derr[inst];
        break;
      end
    end
    dcyc[inst] = 1'b0;
  endtask

  task automatic watch(input int inst, input int cycles, output int acks);
    acks = 0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      if (dack[inst]) acks++;
    end
  endtask

  initial begin
    int          lat, acks;
    logic [63:0] rd;
    logic        er;
    logic [11:0] pattern;

    rst = '1; dcyc = '0; dstb = '0; dwe = '0; dsigned = '0;
    for (int i = 0; i < 3; i++) begin
      dadr[i] = '0; ddat[i] = '0; dsiz[i] = 2'b00;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_dack", 64'(dack), 64'd0);
    check("reset_derr", 64'(derr), 64'd0);
    check("reset_ddat", rdat[0] | rdat[1] | rdat[2], 64'd0);
    rst = '0;

    // ---- WAIT_STATES = 1 ----
    txn(0, 1'b1, 64'h40, 64'h0123_4567_89AB_CDEF, 2'b11, 1'b0, lat, rd, er);
    check("wr_dword_lat", 64'(lat), 64'd2);
    check("wr_dword_derr", 64'(er), 64'd0);
    txn(0, 1'b0, 64'h40, 64'h0, 2'b11, 1'b0, lat, rd, er);
    check("rd_dword_lat", 64'(lat), 64'd2);
    check("rd_dword_data", rd, 64'h0123_4567_89AB_CDEF);
    check("rd_dword_derr", 64'(er), 64'd0);
    txn(0, 1'b0, 64'h47, 64'h0, 2'b00, 1'b1, lat, rd, er);
    check("rd_byte47_s", rd, 64'h0000_0000_0000_0001);
    txn(0, 1'b1, 64'h41, 64'hF0, 2'b00, 1'b0, lat, rd, er);
    check("wr_byte41_lat", 64'(lat), 64'd2);
    txn(0, 1'b0, 64'h41, 64'h0, 2'b00, 1'b1, lat, rd, er);
    check("rd_byte41_s", rd, 64'hFFFF_FFFF_FFFF_FFF0);
    txn(0, 1'b0, 64'h41, 64'h0, 2'b00, 1'b0, lat, rd, er);
    check("rd_byte41_u", rd, 64'h0000_0000_0000_00F0);
    txn(0, 1'b0, 64'h40, 64'h0, 2'b11, 1'b1, lat, rd, er);
    check("rd_dword_after_byte", rd, 64'h0123_4567_89AB_F0EF);
    txn(0, 1'b0, 64'h44, 64'h0, 2'b10, 1'b1, lat, rd, er);
    check("rd_word44_s", rd, 64'h0000_0000_0123_4567);
    txn(0, 1'b0, 64'h46, 64'h0, 2'b01, 1'b1, lat, rd, er);
    check("rd_half46_s", rd, 64'h0000_0000_0000_0123);
    txn(0, 1'b0, 64'h40, 64'h0, 2'b01, 1'b1, lat, rd, er);
    check("rd_half40_s", rd, 64'hFFFF_FFFF_FFFF_F0EF);
    txn(0, 1'b0, 64'h40, 64'h0, 2'b10, 1'b1, lat, rd, er);
    check("rd_word40_s", rd, 64'hFFFF_FFFF_89AB_F0EF);
    txn(0, 1'b0, 64'h40, 64'h0, 2'b10, 1'b0, lat, rd, er);
    check("rd_word40_u", rd, 64'h0000_0000_89AB_F0EF);
    txn(0, 1'b1, 64'h43, 64'hBEEF, 2'b01, 1'b0, lat, rd, er);
    check("mis_wr_lat", 64'(lat), 64'd2);
    check("mis_wr_derr", 64'(er), 64'd1);
    txn(0, 1'b0, 64'h40, 64'h0, 2'b11, 1'b0, lat, rd, er);
    check("mis_wr_unchanged", rd, 64'h0123_4567_89AB_F0EF);
    check("aligned_derr", 64'(er), 64'd0);
    txn(0, 1'b0, 64'h42, 64'h0, 2'b10, 1'b0, lat, rd, er);
    check("mis_rd_derr", 64'(er), 64'd1);
    check("mis_rd_data", rd, 64'd0);
    txn(0, 1'b0, 64'h8040, 64'h0, 2'b11, 1'b0, lat, rd, er);
    check("alias_rd", rd, 64'h0123_4567_89AB_F0EF);

    // ---- WAIT_STATES = 3 ----
    txn(1, 1'b1, 64'h80, 64'h1111_2222_3333_4444, 2'b11, 1'b0, lat, rd, er);
    check("ws3_wr_lat", 64'(lat), 64'd4);
    @(negedge clk);
    dcyc[1] = 1'b1; dstb[1] = 1'b1; dwe[1] = 1'b1; dadr[1] = 64'h80;
    ddat[1] = 64'hDEAD_BEEF_DEAD_BEEF; dsiz[1] = 2'b11;
    @(posedge clk);
    #1 dstb[1] = 1'b0;
    @(negedge clk);
    dcyc[1] = 1'b0;
    watch(1, 8, acks);
    check("abort_no_ack", 64'(acks), 64'd0);
    txn(1, 1'b0, 64'h80, 64'h0, 2'b11, 1'b0, lat, rd, er);
    check("abort_no_write", rd, 64'h1111_2222_3333_4444);
    check("abort_rd_lat", 64'(lat), 64'd4);
    @(negedge clk);
    dcyc[1] = 1'b1; dstb[1] = 1'b1; dwe[1] = 1'b1; dadr[1] = 64'h80;
    ddat[1] = 64'h5555_6666_7777_8888; dsiz[1] = 2'b11;
    @(posedge clk);
    #1 dstb[1] = 1'b0;
    @(negedge clk);
    rst[1] = 1'b1;
    @(negedge clk);
    check("rst_wait_dack", 64'(dack[1]), 64'd0);
    rst[1] = 1'b0;
    dcyc[1] = 1'b0;
    watch(1, 8, acks);
    check("rst_wait_no_ack", 64'(acks), 64'd0);
    txn(1, 1'b0, 64'h80, 64'h0, 2'b11, 1'b0, lat, rd, er);
    check("rst_no_write", rd, 64'h1111_2222_3333_4444);
    check("rst_then_lat", 64'(lat), 64'd4);

    // ---- WAIT_STATES = 0 ----
    @(negedge clk);
    dcyc[2] = 1'b0; dstb[2] = 1'b1; dwe[2] = 1'b0; dadr[2] = 64'h100; dsiz[2] = 2'b11;
    watch(2, 4, acks);
    dstb[2] = 1'b0;
    check("no_cyc_ignored", 64'(acks), 64'd0);
    txn(2, 1'b1, 64'h100, 64'hAAAA_BBBB_CCCC_DDDD, 2'b11, 1'b0, lat, rd, er);
    check("ws0_wr_lat", 64'(lat), 64'd1);
    txn(2, 1'b0, 64'h100, 64'h0, 2'b11, 1'b0, lat, rd, er);
    check("ws0_rd_lat", 64'(lat), 64'd1);
    check("ws0_rd_data", rd, 64'hAAAA_BBBB_CCCC_DDDD);
    @(negedge clk);
    dcyc[2] = 1'b1; dstb[2] = 1'b1; dwe[2] = 1'b0; dadr[2] = 64'h100; dsiz[2] = 2'b11;
    pattern = '0;
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      pattern[i] = dack[2];
      if (dack[2] && rdat[2] !== 64'hAAAA_BBBB_CCCC_DDDD) acks++;
    end
    dcyc[2] = 1'b0; dstb[2] = 1'b0;
    check("b2b_pattern", 64'(pattern), 64'h555);
    check("b2b_data_errs", 64'(acks), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
